wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//   Finish-stage writeback arbiter: the producer side of the vreg writebus. Collects results
//   from NUM_UNITS functional units through per-unit result buffers and drives up to
//   WRITE_PORTS writebus ports per cycle (we, data, reg addr, IQ pos) into the ROB.
//   Round-robin fairness across units, valid/ready back-pressure, and a flush that drops all
//   buffered results.
// PARAMETERS
//   NUM_UNITS    4   functional units feeding writeback
//   WRITE_PORTS  2   writebus ports driven per cycle (<= NUM_UNITS)
//   WORD         32  result width
//   REG_ADDR     5   destination register address width
//   IQ_POS       4   IQ position width (iq_size = 2**IQ_POS)
//   BUF_DEPTH    2   result buffer entries per unit (>= 1)
// PORTS
//   clk        in   1                      clock, all state on rising edge
//   rst        in   1                      asynchronous reset, active-high
//   flush      in   1                      synchronous: discard all buffered results
//   fu_valid   in   NUM_UNITS              unit u presents a result
//   fu_data    in   NUM_UNITS*WORD         result; unit u at [u*WORD +: WORD]
//   fu_addr    in   NUM_UNITS*REG_ADDR     destination register
//   fu_iq_pos  in   NUM_UNITS*IQ_POS       IQ slot of producing instruction
//   fu_ready   out  NUM_UNITS              unit u's buffer can accept
//   wb_we      out  WRITE_PORTS            writebus port k valid
//   wb_data    out  WRITE_PORTS*WORD       writebus data, port k at [k*WORD +: WORD]
//   wb_addr    out  WRITE_PORTS*REG_ADDR   writebus register address
//   wb_iq_pos  out  WRITE_PORTS*IQ_POS     writebus IQ position
// BEHAVIOUR
//   Reset (rst high, async): all buffers empty, rr_ptr=0, wb_we/wb_data/wb_addr/wb_iq_pos=0,
//     fu_ready forced 0 while rst high; fu_ready=1 for all units first cycle after release.
//   Input handshake: transfer on edge where fu_valid[u] && fu_ready[u]; unit holds its fields
//     stable while valid && !ready. fu_ready[u] = (count[u] != BUF_DEPTH) && !rst, from count
//     only: a full buffer refuses input even if it pops the same edge. Per-unit FIFO order.
//   Arbitration (combinational, current cycle): scan units rr_ptr, rr_ptr+1, ... mod NUM_UNITS;
//     first WRITE_PORTS units with non-empty buffers are granted; k-th granted unit -> port k.
//     Granted units pop their head at the edge. rr_ptr <= (last granted unit + 1) mod
//     NUM_UNITS; unchanged if no grant.
//   Output: wb_* are registers loaded at the edge from granted heads; ungranted ports load
//     we=0, data/addr/iq_pos=0. Latency: result accepted at edge E appears on wb_* after edge
//     E+1 (one cycle min. in buffer); no input-to-output bypass.
//   Flush: at the edge where flush=1 all buffers cleared, rr_ptr=0, wb_* loaded as all-zero,
//     input transfers that edge discarded. fu_ready unaffected combinationally.
//   Simultaneous push+pop on a non-full buffer: count unchanged, new entry queued behind.
//   Throughput: at most one pop per unit per cycle; at most WRITE_PORTS results per cycle.
//   Two writebus ports never carry the same unit's results in one cycle. Distinct units must
//   not report the same iq_pos concurrently (issue guarantees; not checked).
//   Pointer arithmetic wraps mod NUM_UNITS; counts saturate by construction (0..BUF_DEPTH).
// TESTING
//   1 Reset: assert rst mid-stream with 3 buffered results -> wb_we=0, fu_ready=0 during
//     rst; after release fu_ready=4'b1111, no stale writes ever appear.
//   2 Latency: unit 2 sends data=0x0000_BEEF addr=5 iq=3 at edge E -> after E+1 wb_we=2'b01,
//     port0 = {0xBEEF,5,3}; wb_we=0 after E+2.
//   3 Round-robin: all 4 units hold 1 result each, rr_ptr=0 -> cycle1 ports {u0,u1},
//     cycle2 {u2,u3}; then u0..u3 refilled continuously -> grant pairs alternate, no starvation.
//   4 Back-pressure: unit 1 valid every cycle, writebus blocked by units 0/2/3 saturating ->
//     fu_ready[1] drops after 2 accepts, held data transfers once ready, FIFO order preserved.
//   5 Flush: 5 results buffered, flush pulse with fu_valid[0]=1 -> next cycle wb_we=0, buffers
//     empty, unit 0 input dropped; following valid result emitted normally, rr_ptr restarts 0.
//   6 Wrap: rr_ptr=3, only units 3 and 0 non-empty -> port0=u3, port1=u0, rr_ptr<=1.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: functional-unit result inputs and the vreg writebus outputs.
interface wb_arbiter_if #(
   parameter int NUM_UNITS   = 4,
   parameter int WRITE_PORTS = 2,
   parameter int WORD        = 32,
   parameter int REG_ADDR    = 5,
   parameter int IQ_POS      = 4
);
   logic [NUM_UNITS-1:0]            fu_valid;
   logic [NUM_UNITS*WORD-1:0]       fu_data;
   logic [NUM_UNITS*REG_ADDR-1:0]   fu_addr;
   logic [NUM_UNITS*IQ_POS-1:0]     fu_iq_pos;
   logic [NUM_UNITS-1:0]            fu_ready;
   logic [WRITE_PORTS-1:0]          wb_we;
   logic [WRITE_PORTS*WORD-1:0]     wb_data;
   logic [WRITE_PORTS*REG_ADDR-1:0] wb_addr;
   logic [WRITE_PORTS*IQ_POS-1:0]   wb_iq_pos;

   modport master (
      output fu_valid, fu_data, fu_addr, fu_iq_pos,
      input  fu_ready, wb_we, wb_data, wb_addr, wb_iq_pos
   );

   modport slave (
      input  fu_valid, fu_data, fu_addr, fu_iq_pos,
      output fu_ready, wb_we, wb_data, wb_addr, wb_iq_pos
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-unit result FIFOs, round-robin onto WRITE_PORTS registered writebus ports.
// Latency: accepted at edge E, on the writebus after E+1. Back-pressure: fu_ready drops when a unit's buffer is full.
module wb_arbiter #(
   parameter int NUM_UNITS   = 4,
   parameter int WRITE_PORTS = 2,
   parameter int WORD        = 32,
   parameter int REG_ADDR    = 5,
   parameter int IQ_POS      = 4,
   parameter int BUF_DEPTH   = 2
) (
   input logic         clk,
   input logic         rst,
   input logic         flush,
   wb_arbiter_if.slave bus
);
   localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);

   typedef struct packed {
      logic [WORD-1:0]     data;
      logic [REG_ADDR-1:0] addr;
      logic [IQ_POS-1:0]   iq_pos;
   } entry_t;

   entry_t                 mem [NUM_UNITS][BUF_DEPTH];
   logic [PW-1:0]          rd_ptr [NUM_UNITS];
   logic [PW-1:0]          wr_ptr [NUM_UNITS];
   logic [CW-1:0]          count [NUM_UNITS];
   logic [UW-1:0]          rr_ptr;

   logic [NUM_UNITS-1:0]   ready;
   logic [NUM_UNITS-1:0]   non_empty;
   logic [NUM_UNITS-1:0]   push;
   logic [NUM_UNITS-1:0]   grant;
   entry_t                 in_ent [NUM_UNITS];
   entry_t                 head [NUM_UNITS];

   logic [WRITE_PORTS-1:0] port_vld;
   logic [UW-1:0]          port_unit [WRITE_PORTS];
   logic [UW-1:0]          scan_unit;
   logic [UW-1:0]          last_unit;
   int                     n_grant;

   logic [WRITE_PORTS-1:0] wb_we_q;
   entry_t                 wb_q [WRITE_PORTS];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [UW-1:0] unit_inc(input logic [UW-1:0] u);
      return (u == UW'(NUM_UNITS - 1)) ? '0 : u + 1'b1;
   endfunction

   // Ready depends on occupancy only, so a full buffer refuses even while it pops.
   always_comb begin
      for (int u = 0; u < NUM_UNITS; u++) begin
         ready[u]         = (count[u] != CW'(BUF_DEPTH)) && !rst;
         non_empty[u]     = (count[u] != '0);
         push[u]          = bus.fu_valid[u] && ready[u];
         in_ent[u].data   = bus.fu_data[u*WORD +: WORD];
         in_ent[u].addr   = bus.fu_addr[u*REG_ADDR +: REG_ADDR];
         in_ent[u].iq_pos = bus.fu_iq_pos[u*IQ_POS +: IQ_POS];
         head[u]          = mem[u][rd_ptr[u]];
      end
   end

   assign bus.fu_ready = ready;

   always_comb begin
      grant     = '0;
      port_vld  = '0;
      scan_unit = rr_ptr;
      last_unit = rr_ptr;
      n_grant   = 0;
      for (int k = 0; k < WRITE_PORTS; k++) begin
         port_unit[k] = '0;
      end
      for (int i = 0; i < NUM_UNITS; i++) begin
         scan_unit = UW'((int'(rr_ptr) + i) % NUM_UNITS);
         if (non_empty[scan_unit] && (n_grant < WRITE_PORTS)) begin
            for (int k = 0; k < WRITE_PORTS; k++) begin
               if (n_grant == k) begin
                  port_vld[k]  = 1'b1;
                  port_unit[k] = scan_unit;
               end
            end
            grant[scan_unit] = 1'b1;
            last_unit        = scan_unit;
            n_grant          = n_grant + 1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!flush) begin
         for (int u = 0; u < NUM_UNITS; u++) begin
            if (push[u]) begin
               mem[u][wr_ptr[u]] <= in_ent[u];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int u = 0; u < NUM_UNITS; u++) begin
            rd_ptr[u] <= '0;
            wr_ptr[u] <= '0;
            count[u]  <= '0;
         end
         rr_ptr  <= '0;
         wb_we_q <= '0;
         for (int k = 0; k < WRITE_PORTS; k++) begin
            wb_q[k] <= '0;
         end
      end else if (flush) begin
         for (int u = 0; u < NUM_UNITS; u++) begin
            rd_ptr[u] <= '0;
            wr_ptr[u] <= '0;
            count[u]  <= '0;
         end
         rr_ptr  <= '0;
         wb_we_q <= '0;
         for (int k = 0; k < WRITE_PORTS; k++) begin
            wb_q[k] <= '0;
         end
      end else begin
         for (int u = 0; u < NUM_UNITS; u++) begin
            if (push[u]) begin
               wr_ptr[u] <= ptr_inc(wr_ptr[u]);
            end
            if (grant[u]) begin
               rd_ptr[u] <= ptr_inc(rd_ptr[u]);
            end
            if (push[u] && !grant[u]) begin
               count[u] <= count[u] + 1'b1;
            end else if (!push[u] && grant[u]) begin
               count[u] <= count[u] - 1'b1;
            end
         end
         if (grant != '0) begin
            rr_ptr <= unit_inc(last_unit);
         end
         wb_we_q <= port_vld;
         for (int k = 0; k < WRITE_PORTS; k++) begin
            wb_q[k] <= port_vld[k] ? head[port_unit[k]] : '0;
         end
      end
   end

   for (genvar k = 0; k < WRITE_PORTS; k++) begin : g_port
      assign bus.wb_data[k*WORD +: WORD]           = wb_q[k].data;
      assign bus.wb_addr[k*REG_ADDR +: REG_ADDR]   = wb_q[k].addr;
      assign bus.wb_iq_pos[k*IQ_POS +: IQ_POS]     = wb_q[k].iq_pos;
   end
   assign bus.wb_we = wb_we_q;

endmodule
